// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared constants and types for the framebuffer scanout
//               arbiter: framebuffer geometry, pixel and address widths,
//               write FIFO depth and the buffer-swap state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

  localparam int FB_H       = 320;   // framebuffer width (display is 2x wide)
  localparam int FB_V       = 240;   // framebuffer height in lines
  localparam int PIX_W      = 12;    // RGB444
  localparam int MEM_LAT    = 1;     // memory read latency in cycles
  localparam int FIFO_DEPTH = 4;     // write FIFO entries, power of two
  localparam int CRD_W      = 10;    // timing-generator coordinate width
  localparam int IDX_W      = 17;    // pixel index width inside one buffer
  localparam int ADDR_W     = IDX_W + 1;  // {buffer bit, pixel index}

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_wr_fifo
// Description : Small synchronous first-word-fall-through FIFO buffering
//               draw-engine writes until a memory write slot is free.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               push, wdata    - enqueue request and entry (ignored if full)
//               pop            - dequeue request (ignored if empty)
//               rdata          - head entry, valid while !empty
//               full, empty    - occupancy flags
//               count          - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module fb_wr_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/framebuffer_scanout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout_arbiter
// Description : Shares one single-port framebuffer memory between display
//               scanout (2x horizontally and vertically scaled) and a draw
//               engine, with double buffering and frame-synchronous swap.
// Ports       : i_clk_pxl, i_reset_n           - pixel clock, async low reset
//               i_sx, i_sy, i_de, i_hsync, i_vsync - timing generator
//               i_wr_valid/addr/data, o_wr_ready   - draw-engine write port
//               i_swap_req, o_swap_ack, o_front    - buffer swap handshake
//               o_mem_*, i_mem_rdata               - memory port
//               o_rgb, o_de, o_hsync, o_vsync      - aligned video output
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout_arbiter #(
  parameter int FB_H       = fb_arb_pkg::FB_H,
  parameter int FB_V       = fb_arb_pkg::FB_V,
  parameter int PIX_W      = fb_arb_pkg::PIX_W,
  parameter int MEM_LAT    = fb_arb_pkg::MEM_LAT,
  parameter int FIFO_DEPTH = fb_arb_pkg::FIFO_DEPTH
) (
  input  logic             i_clk_pxl,
  input  logic             i_reset_n,
  input  logic [9:0]       i_sx,
  input  logic [9:0]       i_sy,
  input  logic             i_de,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_wr_valid,
  input  logic [16:0]      i_wr_addr,
  input  logic [PIX_W-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_swap_req,
  output logic             o_swap_ack,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [17:0]      o_mem_addr,
  output logic [PIX_W-1:0] o_mem_wdata,
  input  logic [PIX_W-1:0] i_mem_rdata,
  output logic [PIX_W-1:0] o_rgb,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_front
);

  import fb_arb_pkg::*;

  localparam int PIX_CNT = FB_H * FB_V;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W   = IDX_W + PIX_W;
  localparam int PIPE_D  = MEM_LAT + 1;

  swap_state_t      state;
  swap_state_t      state_nxt;
  logic             front;
  logic             swap_fire;
  logic             frame_start;
  logic             rd_slot;
  logic             in_range;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_nxt;
  logic [ENT_W-1:0] fifo_head;
  logic [IDX_W-1:0] wr_idx;
  logic [PIX_W-1:0] wr_pix;
  logic [IDX_W-1:0] rd_idx;

  logic [PIPE_D-1:0][2:0] sync_pipe;  // {de, hsync, vsync} per stage
  logic [MEM_LAT-1:0]     rd_pipe;    // marks stages carrying a display read

  // Memory-side strobes are gated by reset directly so nothing reaches the
  // memory in the cycle reset is asserted, even before the next clock edge.
  assign frame_start = (i_sx == '0) && (i_sy == '0);
  assign rd_slot     = i_reset_n && i_de && !i_sx[0];
  assign fifo_pop    = i_reset_n && !rd_slot && !fifo_empty;
  assign in_range    = ({15'd0, i_wr_addr} < 32'(PIX_CNT));
  // Out-of-range writes are acknowledged but simply never enqueued.
  assign fifo_push   = i_wr_valid && o_wr_ready && in_range && !fifo_full;
  assign count_nxt   = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  assign rd_idx      = IDX_W'(({23'd0, i_sy[9:1]} * 32'(FB_H)) + {23'd0, i_sx[9:1]});
  assign {wr_idx, wr_pix} = fifo_head;

  fb_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_wr_fifo (
    .clk   (i_clk_pxl),
    .rst_n (i_reset_n),
    .push  (fifo_push),
    .wdata ({i_wr_addr, i_wr_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Swap FSM: while PENDING the write port is closed so the FIFO drains;
  // the swap only lands on a frame start with nothing left to write.
  always_comb begin
    state_nxt = state;
    swap_fire = 1'b0;
    case (state)
      IDLE:    if (i_swap_req) state_nxt = PENDING;
      PENDING: if (frame_start && fifo_empty) begin
                 state_nxt = IDLE;
                 swap_fire = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      front      <= 1'b0;
      o_wr_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (swap_fire) front <= ~front;
      o_wr_ready <= (count_nxt < CNT_W'(FIFO_DEPTH)) && (state_nxt == IDLE);
    end
  end

  // The new buffer is already used by the frame-start read itself, so the
  // first pixel of the new frame comes from the freshly drawn buffer.
  assign o_front    = front ^ swap_fire;
  assign o_swap_ack = swap_fire;

  always_comb begin
    o_mem_en    = rd_slot || fifo_pop;
    o_mem_we    = fifo_pop;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (rd_slot) begin
      o_mem_addr = {o_front, rd_idx};
    end else if (fifo_pop) begin
      o_mem_addr  = {~o_front, wr_idx};
      o_mem_wdata = wr_pix;
    end
  end

  // Video pipeline: read data arrives MEM_LAT cycles after the address and is
  // registered once more, so timing outputs are delayed MEM_LAT+1 cycles.
  // o_rgb doubles as the held pixel for odd columns.
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_pipe <= '0;
      rd_pipe   <= '0;
      o_rgb     <= '0;
    end else begin
      sync_pipe  <= {sync_pipe[PIPE_D-2:0], {i_de, i_hsync, i_vsync}};
      rd_pipe[0] <= rd_slot;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (rd_pipe[MEM_LAT-1])              o_rgb <= i_mem_rdata;
      else if (!sync_pipe[MEM_LAT-1][2])   o_rgb <= '0;
    end
  end

  assign {o_de, o_hsync, o_vsync} = sync_pipe[MEM_LAT];

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout_arbiter
// Description : Directed self-checking bench for framebuffer_scanout_arbiter.
//               Memory model returns the low address bits as read data; all
//               memory writes are logged and compared with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout_arbiter;

  logic        i_clk_pxl  = 1'b0;
  logic        i_reset_n  = 1'b0;
  logic [9:0]  i_sx       = '0;
  logic [9:0]  i_sy       = '0;
  logic        i_de       = 1'b0;
  logic        i_hsync    = 1'b0;
  logic        i_vsync    = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic [16:0] i_wr_addr  = '0;
  logic [11:0] i_wr_data  = '0;
  logic        i_swap_req = 1'b0;
  logic [11:0] i_mem_rdata = '0;
  logic        o_wr_ready, o_swap_ack, o_mem_en, o_mem_we;
  logic [17:0] o_mem_addr;
  logic [11:0] o_mem_wdata, o_rgb;
  logic        o_de, o_hsync, o_vsync, o_front;

  always #5 i_clk_pxl = ~i_clk_pxl;

  framebuffer_scanout_arbiter dut (
    .i_clk_pxl  (i_clk_pxl),  .i_reset_n  (i_reset_n),
    .i_sx       (i_sx),       .i_sy       (i_sy),
    .i_de       (i_de),       .i_hsync    (i_hsync),    .i_vsync (i_vsync),
    .i_wr_valid (i_wr_valid), .i_wr_addr  (i_wr_addr),  .i_wr_data (i_wr_data),
    .o_wr_ready (o_wr_ready), .i_swap_req (i_swap_req), .o_swap_ack (o_swap_ack),
    .o_mem_en   (o_mem_en),   .o_mem_we   (o_mem_we),   .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),.i_mem_rdata(i_mem_rdata),.o_rgb (o_rgb),
    .o_de       (o_de),       .o_hsync    (o_hsync),    .o_vsync (o_vsync),
    .o_front    (o_front)
  );

  // One-cycle-latency memory: read data equals the low address bits.
  always @(posedge i_clk_pxl) begin
    if (o_mem_en && !o_mem_we) i_mem_rdata <= o_mem_addr[11:0];
  end

  logic [29:0] wr_log[$];
  int          wr_sx[$];
  int          wr_total   = 0;
  int          even_hits  = 0;

  always @(posedge i_clk_pxl) begin
    if (o_mem_en && o_mem_we) begin
      wr_log.push_back({o_mem_addr, o_mem_wdata});
      wr_sx.push_back(int'(i_sx));
      wr_total++;
      if (i_de && !i_sx[0]) even_hits++;
    end
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [29:0] sb[$];
  int          acc_total = 0;
  int          max_out   = 0;
  logic        model_front = 1'b0;
  logic [11:0] m_hold = '0;
  logic [11:0] h1_rgb = '0, h2_rgb = '0;
  logic [2:0]  h1_sync = '0, h2_sync = '0;
  logic        s_ack, s_front, s_en, s_we, s_ready;
  logic [17:0] s_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic pos(input int sx, input int sy, input logic de);
    i_sx    = 10'(sx);
    i_sy    = 10'(sy);
    i_de    = de;
    i_hsync = i_sx[3];
    i_vsync = i_sx[6] ^ i_sy[0];
  endtask

  // One pixel clock: check delayed video outputs against the model history,
  // sample combinational outputs, book accepted writes, then advance.
  task automatic cycle();
    logic [11:0] cur_rgb;
    logic [2:0]  cur_sync;
    int          ix;
    if (!i_reset_n) begin
      h1_rgb = '0; h2_rgb = '0; h1_sync = '0; h2_sync = '0; m_hold = '0;
    end
    #2;
    check_eq("rgb", 32'(o_rgb), 32'(h2_rgb));
    check_eq("de_hs_vs", 32'({o_de, o_hsync, o_vsync}), 32'(h2_sync));
    s_ack = o_swap_ack; s_front = o_front; s_en = o_mem_en;
    s_we = o_mem_we; s_addr = o_mem_addr; s_ready = o_wr_ready;
    if (i_reset_n && i_wr_valid && o_wr_ready && (i_wr_addr < 17'd76800)) begin
      sb.push_back({~model_front, i_wr_addr, i_wr_data});
      acc_total++;
    end
    if (acc_total - wr_total > max_out) max_out = acc_total - wr_total;
    if (i_reset_n && i_de) begin
      if (!i_sx[0]) begin
        ix = int'(i_sy[9:1]) * 320 + int'(i_sx[9:1]);
        m_hold = 12'(ix);
      end
      cur_rgb = m_hold;
    end else begin
      m_hold  = '0;
      cur_rgb = '0;
    end
    cur_sync = i_reset_n ? {i_de, i_hsync, i_vsync} : 3'b000;
    @(posedge i_clk_pxl);
    #1;
    h2_rgb = h1_rgb; h2_sync = h1_sync;
    h1_rgb = cur_rgb; h1_sync = cur_sync;
  endtask

  task automatic compare_log(input string tag);
    check_eq({tag, "_count"}, 32'(wr_log.size()), 32'(sb.size()));
    for (int i = 0; i < wr_log.size() && i < sb.size(); i++)
      check_eq(tag, 32'(wr_log[i]), 32'(sb[i]));
    wr_log.delete(); wr_sx.delete(); sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, toggles;
    logic prev_ready;
    @(posedge i_clk_pxl); #1;

    // Reset with active video driven: nothing may leak out.
    pos(0, 0, 1);
    repeat (3) begin
      cycle();
      check_eq("rst_mem_en", 32'(s_en), 0);
      check_eq("rst_ready", 32'(s_ready), 0);
      check_eq("rst_front", 32'(s_front), 0);
    end
    i_reset_n = 1'b1;
    pos(700, 0, 0); cycle(); check_eq("ready_before_edge", 32'(s_ready), 0);
    pos(701, 0, 0); cycle(); check_eq("ready_after_release", 32'(s_ready), 1);

    // Pipeline alignment over a full active line.
    for (int x = 0; x < 640; x++) begin
      pos(x, 0, 1); cycle();
      if (x == 2) begin
        check_eq("rd_addr_x2", 32'(s_addr), 32'd1);
        check_eq("rd_is_read", 32'(s_we), 0);
      end
    end
    for (int x = 640; x < 645; x++) begin
      pos(x, 0, 0); cycle(); check_eq("blank_mem_idle", 32'(s_en), 0);
    end

    // Single write during active video.
    for (int x = 96; x < 110; x++) begin
      pos(x, 2, 1);
      i_wr_valid = (x == 100); i_wr_addr = 17'd5; i_wr_data = 12'hABC;
      cycle();
      if (x == 104) check_eq("rd_addr_line2", 32'(s_addr), 32'd372);
    end
    i_wr_valid = 1'b0;
    if (wr_sx.size() > 0) check_eq("wr_column", 32'(wr_sx[0]), 32'd101);
    check_eq("wr_expected_value", 32'(sb.size() > 0 ? sb[0] : 30'd0), 32'({18'h20005, 12'hABC}));
    compare_log("wr_active");

    // Out-of-range write is accepted but dropped; last valid index is kept.
    pos(700, 3, 0);
    i_wr_valid = 1'b1; i_wr_addr = 17'd76800; i_wr_data = 12'h123;
    cycle(); check_eq("oor_accepted", 32'(s_ready), 1);
    i_wr_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      pos(701 + j, 3, 0); cycle(); check_eq("oor_mem_idle", 32'(s_en), 0);
    end
    check_eq("oor_no_write", 32'(wr_log.size()), 0);
    i_wr_valid = 1'b1; i_wr_addr = 17'd76799; i_wr_data = 12'h5A5;
    pos(710, 3, 0); cycle();
    i_wr_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin pos(711 + j, 3, 0); cycle(); end
    compare_log("last_index");

    // Backpressure: continuous writes through an active line.
    k = 0; toggles = 0; prev_ready = 1'b1; max_out = 0;
    acc_total = 0; wr_total = 0;
    i_wr_valid = 1'b1;
    for (int x = 0; x < 640; x++) begin
      pos(x, 4, 1);
      i_wr_addr = 17'(1000 + k); i_wr_data = 12'(k + 256);
      cycle();
      if (s_ready) k++;
      if (!prev_ready && s_ready) toggles++;
      prev_ready = s_ready;
    end
    i_wr_valid = 1'b0;
    for (int x = 640; x < 652; x++) begin pos(x, 4, 0); cycle(); end
    check_eq("max_buffered_le_depth", 32'(max_out <= 4), 1);
    check_eq("ready_toggled", 32'(toggles > 0), 1);
    compare_log("backpressure");

    // Swap requested with 3 entries queued: deferred one frame start.
    i_wr_valid = 1'b1;
    for (int x = 0; x < 6; x++) begin
      pos(x, 10, 1); i_wr_addr = 17'(2000 + x); i_wr_data = 12'(x + 12'h300);
      cycle();
    end
    i_wr_valid = 1'b0;
    pos(6, 10, 1); i_swap_req = 1'b1; cycle();
    i_swap_req = 1'b0;
    pos(0, 0, 1); cycle();
    check_eq("deferred_no_ack", 32'(s_ack), 0);
    check_eq("deferred_front", 32'(s_front), 0);
    check_eq("pending_ready_low", 32'(s_ready), 0);
    for (int x = 1; x < 10; x++) begin pos(x, 0, 1); cycle(); end
    check_eq("pending_ready_still_low", 32'(s_ready), 0);
    for (int j = 0; j < 3; j++) begin pos(700 + j, 0, 0); cycle(); end
    compare_log("pre_swap");
    pos(0, 0, 1); i_swap_req = 1'b1; cycle();
    model_front = 1'b1;
    check_eq("swap_ack", 32'(s_ack), 1);
    check_eq("swap_front", 32'(s_front), 1);
    check_eq("swap_rd_addr", 32'(s_addr), 32'h20000);
    i_swap_req = 1'b0;
    pos(1, 0, 1); cycle();
    check_eq("ack_one_cycle", 32'(s_ack), 0);
    check_eq("front_held", 32'(s_front), 1);
    check_eq("ready_after_swap", 32'(s_ready), 1);
    pos(2, 0, 1); cycle(); check_eq("new_buf_rd_addr", 32'(s_addr), 32'h20001);
    pos(700, 0, 0); i_wr_valid = 1'b1; i_wr_addr = 17'd9; i_wr_data = 12'h0F0;
    cycle();
    i_wr_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin pos(701 + j, 0, 0); cycle(); end
    compare_log("post_swap");
    pos(0, 0, 1); cycle(); check_eq("req_on_swap_ignored", 32'(s_ack), 0);

    // Reset mid-frame with a full FIFO and a pending swap.
    i_wr_valid = 1'b1;
    for (int x = 0; x < 9; x++) begin
      pos(x, 200, 1); i_wr_addr = 17'(3000 + x); i_wr_data = 12'(x);
      i_swap_req = (x == 8);
      cycle();
    end
    i_wr_valid = 1'b0; i_swap_req = 1'b0;
    wr_log.delete(); wr_sx.delete(); sb.delete();
    i_reset_n = 1'b0; model_front = 1'b0;
    pos(9, 200, 1); cycle();
    check_eq("rst_now_mem_en", 32'(s_en), 0);
    check_eq("rst_now_mem_we", 32'(s_we), 0);
    check_eq("rst_now_ready", 32'(s_ready), 0);
    check_eq("rst_now_front", 32'(s_front), 0);
    check_eq("rst_now_ack", 32'(s_ack), 0);
    pos(10, 200, 1); cycle();
    pos(11, 200, 1); cycle();
    check_eq("rst_no_write", 32'(wr_log.size()), 0);
    i_reset_n = 1'b1;
    pos(12, 200, 1); cycle();
    pos(13, 200, 1); cycle();
    check_eq("rerelease_ready", 32'(s_ready), 1);
    check_eq("rerelease_front", 32'(s_front), 0);
    for (int x = 14; x < 22; x++) begin pos(x, 200, 1); cycle(); end
    check_eq("fifo_discarded", 32'(wr_log.size()), 0);
    pos(0, 0, 1); cycle();
    check_eq("pending_discarded", 32'(s_ack), 0);
    check_eq("front_after_rst", 32'(s_front), 0);
    check_eq("even_column_writes", 32'(even_hits), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
